// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
// Holds the tracked-writer entry, the unused-operand marker and stage ids.
package hazard_pkg;

   // Width of the T_use / T_new fields carried in each entry.
   localparam int HZ_TW = 2;

   // T_use value meaning "operand not read by this instruction".
   localparam logic [HZ_TW-1:0] TUSE_NONE = '1;

   // Stage numbering downstream of Decode.
   localparam int STG_E = 1;
   localparam int STG_M = 2;
   localparam int STG_W = 3;

   typedef struct packed {
      logic             valid;
      logic [4:0]       dst;
      logic [HZ_TW-1:0] t_new;
   } entry_t;

   // One cycle of ageing: count down, never below zero.
   function automatic logic [HZ_TW-1:0] tnew_age(
      input logic [HZ_TW-1:0] t
   );
      return (t == '0) ? '0 : t - HZ_TW'(1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: Decode <-> scoreboard bundle.
// master = Decode (drives d_*/md_*), slave = scoreboard (drives stall/sels).
// md_* signals exist only when HAZARD_MDU_EN is defined.
interface hazard_scoreboard_if #(
   parameter int TW   = 2,
   parameter int SELW = 2
);

   logic [4:0]      d_rs;
   logic [4:0]      d_rt;
   logic [TW-1:0]   d_tuse_rs;
   logic [TW-1:0]   d_tuse_rt;
   logic            d_wen;
   logic [4:0]      d_dst;
   logic [TW-1:0]   d_tnew;
   logic            stall;
   logic [SELW-1:0] fwd_rs_sel;
   logic [SELW-1:0] fwd_rt_sel;
`ifdef HAZARD_MDU_EN
   logic            md_start;
   logic            md_is_div;
   logic            md_use;
   logic            md_busy;
`endif

   modport master (
      output d_rs, d_rt, d_tuse_rs, d_tuse_rt,
      output d_wen, d_dst, d_tnew,
`ifdef HAZARD_MDU_EN
      output md_start, md_is_div, md_use,
      input  md_busy,
`endif
      input  stall, fwd_rs_sel, fwd_rt_sel
   );

   modport slave (
      input  d_rs, d_rt, d_tuse_rs, d_tuse_rt,
      input  d_wen, d_dst, d_tnew,
`ifdef HAZARD_MDU_EN
      input  md_start, md_is_div, md_use,
      output md_busy,
`endif
      output stall, fwd_rs_sel, fwd_rt_sel
   );

endinterface

// File: rtl/hazard_scoreboard_md_counter.sv
// hazard_md_counter: MDU busy countdown (used when HAZARD_MDU_EN is defined).
// Ports: clk, reset (sync, active-high), start_i, is_div_i, busy_o.
module hazard_md_counter #(
   parameter int MD_LAT  = 5,
   parameter int DIV_LAT = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic is_div_i,
   output logic busy_o
);

   localparam int MAXLAT = (DIV_LAT > MD_LAT) ? DIV_LAT : MD_LAT;
   localparam int CW     = $clog2(MAXLAT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = is_div_i ? CW'(DIV_LAT) : CW'(MD_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall and operand-forward select generator.
// Ports: clk, reset (sync, active-high), hz (slave: D-stage operands,
// writer info, stall, fwd_rs_sel, fwd_rt_sel; md_* with HAZARD_MDU_EN).
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int TW    = HZ_TW,
   parameter int SELW  = 2
`ifdef HAZARD_MDU_EN
   ,parameter int MD_LAT  = 5
   ,parameter int DIV_LAT = 10
`endif
) (
   input  logic               clk,
   input  logic               reset,
   hazard_scoreboard_if.slave hz
);

   entry_t ent_q [1:DEPTH];
   entry_t ent_d [1:DEPTH];

   logic [DEPTH:1] m_rs;
   logic [DEPTH:1] m_rt;

   logic            hit_rs;
   logic            hit_rt;
   logic [SELW-1:0] near_rs;
   logic [SELW-1:0] near_rt;
   logic [TW-1:0]   tnew_rs;
   logic [TW-1:0]   tnew_rt;
   logic            stall_rs;
   logic            stall_rt;
   logic            md_stall;
   logic            stall;

   // Per-stage match; $0 is never a hazard.
   for (genvar k = 1; k <= DEPTH; k++) begin : g_match
      assign m_rs[k] = ent_q[k].valid && (ent_q[k].dst == hz.d_rs)
                       && (hz.d_rs != 5'd0);
      assign m_rt[k] = ent_q[k].valid && (ent_q[k].dst == hz.d_rt)
                       && (hz.d_rt != 5'd0);
   end

   // Scan oldest to youngest so the youngest match is left standing.
   always_comb begin
      hit_rs  = 1'b0;
      hit_rt  = 1'b0;
      near_rs = '0;
      near_rt = '0;
      tnew_rs = '0;
      tnew_rt = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (m_rs[k]) begin
            hit_rs  = 1'b1;
            near_rs = SELW'(k);
            tnew_rs = ent_q[k].t_new;
         end
         if (m_rt[k]) begin
            hit_rt  = 1'b1;
            near_rt = SELW'(k);
            tnew_rt = ent_q[k].t_new;
         end
      end
   end

   assign stall_rs = hit_rs && (hz.d_tuse_rs != TUSE_NONE)
                     && (tnew_rs > hz.d_tuse_rs);
   assign stall_rt = hit_rt && (hz.d_tuse_rt != TUSE_NONE)
                     && (tnew_rt > hz.d_tuse_rt);

`ifdef HAZARD_MDU_EN
   logic md_busy;

   hazard_md_counter #(
      .MD_LAT  (MD_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md (
      .clk      (clk),
      .reset    (reset),
      .start_i  (hz.md_start && !stall),
      .is_div_i (hz.md_is_div),
      .busy_o   (md_busy)
   );

   assign md_stall   = hz.md_use && md_busy;
   assign hz.md_busy = md_busy;
`else
   assign md_stall = 1'b0;
`endif

   assign stall = stall_rs || stall_rt || md_stall;

   // A not-yet-ready producer selects 0; the later mux picks it up.
   assign hz.stall      = stall;
   assign hz.fwd_rs_sel = (!stall && hit_rs && tnew_rs == '0) ? near_rs : '0;
   assign hz.fwd_rt_sel = (!stall && hit_rt && tnew_rt == '0) ? near_rt : '0;

   // Shift register: E takes the D writer (or a bubble), the rest age.
   always_comb begin
      for (int k = 1; k <= DEPTH; k++) begin
         ent_d[k] = '0;
      end
      if (!stall && hz.d_wen && hz.d_dst != 5'd0) begin
         ent_d[STG_E].valid = 1'b1;
         ent_d[STG_E].dst   = hz.d_dst;
         ent_d[STG_E].t_new = hz.d_tnew;
      end
      for (int k = 2; k <= DEPTH; k++) begin
         ent_d[k]       = ent_q[k-1];
         ent_d[k].t_new = tnew_age(ent_q[k-1].t_new);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= DEPTH; k++) begin
            ent_q[k] <= '0;
         end
      end else begin
         ent_q <= ent_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed hazard cases plus random traffic,
// checked against a writer-list model (HAZARD_MDU_EN adds MDU cases).
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   localparam int DEPTH   = 3;
   localparam int MD_LAT  = 5;
   localparam int DIV_LAT = 10;

   logic clk;
   logic reset;

   hazard_scoreboard_if #(.TW(2), .SELW(2)) hz_if ();

   hazard_scoreboard #(
      .DEPTH (DEPTH),
      .TW    (2),
      .SELW  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit rst;
      int rs;
      int rt;
      int tuse_rs;
      int tuse_rt;
      bit wen;
      int dst;
      int tnew;
      bit mds;
      bit mdd;
      bit mdu;
   } drv_t;

   // Writer record: destination, latency, cycle it sat in E.
   typedef struct {
      int dst;
      int tnew;
      int enter;
   } wr_t;

   wr_t pipe [$];
   int  cyc;
   int  md_end;
   int  n_cmp;
   int  n_bad;

   task automatic chk(input string tag, input logic [31:0] got,
                      input int exp);
      n_cmp++;
      if (got !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic drv_t nop();
      drv_t d;
      d.rst = 0; d.rs = 0; d.rt = 0;
      d.tuse_rs = 3; d.tuse_rt = 3;
      d.wen = 0; d.dst = 0; d.tnew = 0;
      d.mds = 0; d.mdd = 0; d.mdu = 0;
      return d;
   endfunction

   function automatic drv_t wr(input int dst, input int tnew);
      drv_t d;
      d = nop();
      d.wen = 1; d.dst = dst; d.tnew = tnew;
      return d;
   endfunction

   function automatic drv_t rd(input int rs, input int tu_rs,
                               input int rt, input int tu_rt);
      drv_t d;
      d = nop();
      d.rs = rs; d.tuse_rs = tu_rs;
      d.rt = rt; d.tuse_rt = tu_rt;
      return d;
   endfunction

   // Youngest in-flight writer of r: its stage and remaining latency.
   function automatic void nearest(input int r, output int stg,
                                   output int rem);
      stg = 0;
      rem = 0;
      if (r == 0) return;
      foreach (pipe[i]) begin
         int s;
         s = cyc - pipe[i].enter + 1;
         if (pipe[i].dst == r && s >= 1 && s <= DEPTH
             && (stg == 0 || s < stg)) begin
            stg = s;
            rem = pipe[i].tnew - (s - 1);
            if (rem < 0) rem = 0;
         end
      end
   endfunction

   task automatic cycle(input drv_t d, output int o_stall,
                        output int o_rs, output int o_rt);
      int  srs, rrs, srt, rrt;
      int  e_rs, e_rt;
      bit  e_stall;
      wr_t w;
      reset           = d.rst;
      hz_if.d_rs      = 5'(d.rs);
      hz_if.d_rt      = 5'(d.rt);
      hz_if.d_tuse_rs = 2'(d.tuse_rs);
      hz_if.d_tuse_rt = 2'(d.tuse_rt);
      hz_if.d_wen     = d.wen;
      hz_if.d_dst     = 5'(d.dst);
      hz_if.d_tnew    = 2'(d.tnew);
`ifdef HAZARD_MDU_EN
      hz_if.md_start  = d.mds;
      hz_if.md_is_div = d.mdd;
      hz_if.md_use    = d.mdu;
`endif
      @(negedge clk);
      nearest(d.rs, srs, rrs);
      nearest(d.rt, srt, rrt);
      e_stall = (srs != 0 && d.tuse_rs != 3 && rrs > d.tuse_rs)
             || (srt != 0 && d.tuse_rt != 3 && rrt > d.tuse_rt);
`ifdef HAZARD_MDU_EN
      chk("md_busy", 32'(hz_if.md_busy), int'(cyc < md_end));
      if (d.mdu && cyc < md_end) e_stall = 1;
`endif
      e_rs = (!e_stall && srs != 0 && rrs == 0) ? srs : 0;
      e_rt = (!e_stall && srt != 0 && rrt == 0) ? srt : 0;
      chk("stall", 32'(hz_if.stall), int'(e_stall));
      chk("fwd_rs_sel", 32'(hz_if.fwd_rs_sel), e_rs);
      chk("fwd_rt_sel", 32'(hz_if.fwd_rt_sel), e_rt);
      o_stall = int'(hz_if.stall);
      o_rs    = int'(hz_if.fwd_rs_sel);
      o_rt    = int'(hz_if.fwd_rt_sel);
      if (d.rst) begin
         pipe.delete();
         md_end = 0;
      end else begin
         if (!e_stall && d.wen && d.dst != 0) begin
            w.dst = d.dst; w.tnew = d.tnew; w.enter = cyc + 1;
            pipe.push_back(w);
         end
         if (!e_stall && d.mds)
            md_end = cyc + 1 + (d.mdd ? DIV_LAT : MD_LAT);
      end
      @(posedge clk);
      cyc++;
      for (int i = pipe.size() - 1; i >= 0; i--)
         if (cyc - pipe[i].enter + 1 > DEPTH) pipe.delete(i);
      #1;
   endtask

   int   st, sr, st2;
   drv_t d;

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; md_end = 0;
      reset = 1'b1;
      hz_if.d_rs = '0; hz_if.d_rt = '0;
      hz_if.d_tuse_rs = '1; hz_if.d_tuse_rt = '1;
      hz_if.d_wen = 1'b0; hz_if.d_dst = '0; hz_if.d_tnew = '0;
`ifdef HAZARD_MDU_EN
      hz_if.md_start = 1'b0; hz_if.md_is_div = 1'b0; hz_if.md_use = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      cycle(rd(1, 0, 2, 0), st, sr, st2);
      chk("rst stall", 32'(st), 0);
      chk("rst sel", 32'(sr), 0);

      // lw $1 then dependent addu
      cycle(wr(1, 2), st, sr, st2);
      d = rd(1, 1, 3, 1); d.wen = 1; d.dst = 2; d.tnew = 1;
      cycle(d, st, sr, st2);
      chk("t1 stall", 32'(st), 1);
      cycle(d, st, sr, st2);
      chk("t1 release", 32'(st), 0);
      chk("t1 sel notready", 32'(sr), 0);
      cycle(d, st, sr, st2);
      chk("t1 sel W", 32'(sr), STG_W);

      // addu $4 then beq $4
      cycle(wr(4, 1), st, sr, st2);
      cycle(rd(4, 0, 0, 3), st, sr, st2);
      chk("t2 stall", 32'(st), 1);
      cycle(rd(4, 0, 0, 3), st, sr, st2);
      chk("t2 release", 32'(st), 0);
      chk("t2 sel M", 32'(sr), STG_M);

      // Two writers of $5: youngest wins
      cycle(wr(5, 1), st, sr, st2);
      cycle(wr(5, 1), st, sr, st2);
      d = rd(5, 1, 0, 3); d.wen = 1; d.dst = 6; d.tnew = 1;
      cycle(d, st, sr, st2);
      chk("t3 stall", 32'(st), 0);
      chk("t3 sel E notready", 32'(sr), 0);
      cycle(d, st, sr, st2);
      chk("t3 sel youngest", 32'(sr), STG_M);

      // $0 never matches
      cycle(wr(0, 2), st, sr, st2);
      cycle(rd(0, 0, 0, 0), st, sr, st2);
      chk("t4 stall", 32'(st), 0);
      chk("t4 sel", 32'(sr + st2), 0);

      // Reset mid-flight
      cycle(wr(7, 2), st, sr, st2);
      d = rd(7, 1, 7, 1); d.rst = 1;
      cycle(d, st, sr, st2);
      chk("t5 pre-reset stall", 32'(st), 1);
      cycle(rd(7, 1, 7, 1), st, sr, st2);
      chk("t5 stall", 32'(st), 0);
      chk("t5 sels", 32'(sr + st2), 0);

`ifdef HAZARD_MDU_EN
      // div then mflo: stall exactly DIV_LAT cycles
      begin
         int n;
         bit done;
         n = 0;
         done = 0;
         d = nop(); d.mds = 1; d.mdd = 1; d.mdu = 1;
         cycle(d, st, sr, st2);
         chk("t6 div issue", 32'(st), 0);
         d = nop(); d.mdu = 1;
         for (int i = 0; i < 40 && !done; i++) begin
            cycle(d, st, sr, st2);
            if (st != 0) n++;
            else done = 1;
         end
         chk("t6 released", 32'(done), 1);
         chk("t6 stall cycles", 32'(n), DIV_LAT);
      end
`endif

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         d = nop();
         d.rst     = ($urandom_range(0, 39) == 0);
         d.rs      = $urandom_range(0, 7);
         d.rt      = $urandom_range(0, 7);
         d.tuse_rs = $urandom_range(0, 3);
         d.tuse_rt = $urandom_range(0, 3);
         d.wen     = $urandom_range(0, 3) != 0;
         d.dst     = $urandom_range(0, 7);
         d.tnew    = $urandom_range(0, 3);
         d.mds     = ($urandom_range(0, 7) == 0);
         d.mdd     = $urandom_range(0, 1);
         d.mdu     = ($urandom_range(0, 3) == 0);
         cycle(d, st, sr, st2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
